// File: rtl/spi_controller.sv
// Host-side SPI initiator: shifts an address byte then cmd_len data bytes on pico, optionally
// captures poci readback, and closes each frame with an IDLE_GAP-cycle sclk-low window.
// Optional readback path enabled by defining SPI_READBACK_EN.
module spi_controller #(
    parameter int CLK_DIV   = 4,
    parameter int IDLE_GAP  = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       iclk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       underrun,
    output logic       busy,
    output logic       sclk,
    output logic       pico,
    input  logic       poci
);

    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W     = $clog2(IDLE_GAP + 1);
    localparam int STALL_LIM = (IDLE_GAP / 2 > 0) ? IDLE_GAP / 2 : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(IDLE_GAP - 1);
    localparam logic [GAP_W-1:0] STALL_LAST = GAP_W'(STALL_LIM - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_ADDR,
        ST_LOAD,
        ST_SHIFT_DATA,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [5:0]       byte_cnt;
    logic [5:0]       len_q;
    logic [GAP_W-1:0] wait_cnt;
    logic [7:0]       tx_shreg;

    logic shifting;
    logic div_last;
    logic bit_done;
    logic byte_done;
    logic stall_expire;

    // Bit of a byte that goes out in position idx of the serial order.
    function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] idx);
        return LSB_FIRST ? b[idx] : b[3'd7 - idx];
    endfunction

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cmd_ready    = 1'b0;
        tx_ready     = 1'b0;
        busy         = 1'b1;
        shifting     = (state_q == ST_SHIFT_ADDR) || (state_q == ST_SHIFT_DATA);
        div_last     = (div_cnt == DIV_LAST);
        bit_done     = shifting && sclk && div_last;
        byte_done    = bit_done && (bit_cnt == 3'd7);
        stall_expire = (state_q == ST_LOAD) && !tx_valid && (wait_cnt == STALL_LAST);

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_d = ST_SHIFT_ADDR;
            end
            ST_SHIFT_ADDR: begin
                if (byte_done) state_d = (len_q == 6'd0) ? ST_GAP : ST_LOAD;
            end
            ST_LOAD: begin
                tx_ready = 1'b1;
                if (tx_valid)          state_d = ST_SHIFT_DATA;
                else if (stall_expire) state_d = ST_GAP;
            end
            ST_SHIFT_DATA: begin
                if (byte_done) state_d = (byte_cnt == len_q) ? ST_GAP : ST_LOAD;
            end
            ST_GAP: begin
                if (wait_cnt == GAP_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            sclk     <= 1'b0;
            pico     <= 1'b0;
            underrun <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            len_q    <= '0;
            wait_cnt <= '0;
            tx_shreg <= '0;
        end else begin
            underrun <= stall_expire;

            // wait_cnt times both the LOAD stall and the GAP window; it restarts on every state change.
            if (state_d != state_q)
                wait_cnt <= '0;
            else if ((state_q == ST_LOAD) || (state_q == ST_GAP))
                wait_cnt <= wait_cnt + GAP_W'(1);

            case (state_q)
                ST_IDLE: begin
                    sclk <= 1'b0;
                    if (cmd_valid) begin
                        len_q    <= cmd_len;
                        tx_shreg <= cmd_addr;
                        pico     <= pick_bit(cmd_addr, 3'd0);
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end
                ST_SHIFT_ADDR, ST_SHIFT_DATA: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                if (state_d == ST_GAP) pico <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                pico    <= pick_bit(tx_shreg, bit_cnt + 3'd1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_LOAD: begin
                    sclk <= 1'b0;
                    if (tx_valid) begin
                        tx_shreg <= tx_data;
                        pico     <= pick_bit(tx_data, 3'd0);
                        byte_cnt <= byte_cnt + 6'd1;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end else if (stall_expire) begin
                        pico <= 1'b0;
                    end
                end
                ST_GAP: begin
                    sclk <= 1'b0;
                    pico <= 1'b0;
                end
                default: begin
                    sclk <= 1'b0;
                    pico <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] rx_shreg;
    logic [7:0] rx_next;

    // poci is sampled on the edge that ends the high phase, same edge that drops sclk.
    always_comb begin
        rx_next = LSB_FIRST ? {poci, rx_shreg[7:1]} : {rx_shreg[6:0], poci};
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            rx_shreg <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (bit_done) rx_shreg <= rx_next;
            if (byte_done && (state_q == ST_SHIFT_DATA)) begin
                rx_valid <= 1'b1;
                rx_data  <= rx_next;
            end
        end
    end
`else
    logic unused_poci;

    assign unused_poci = poci;
    assign rx_valid    = 1'b0;
    assign rx_data     = 8'h00;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: a bit-level peripheral model decodes pico into a
// register map and drives poci, while per-frame expectations come from the frame rules.
module tb_spi_controller;

    localparam int CLK_DIV  = 2;
    localparam int IDLE_GAP = 32;
    localparam int BYTE_CYC = 16 * CLK_DIV;
    localparam int STALL    = IDLE_GAP / 2;
`ifdef SPI_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic       iclk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [5:0] cmd_len = '0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       poci = 1'b0;
    logic       cmd_ready, tx_ready, rx_valid, underrun, busy, sclk, pico;
    logic [7:0] rx_data;

    spi_controller #(.CLK_DIV(CLK_DIV), .IDLE_GAP(IDLE_GAP), .LSB_FIRST(1'b1)) dut (
        .iclk(iclk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .underrun(underrun), .busy(busy),
        .sclk(sclk), .pico(pico), .poci(poci)
    );

    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_fail   = 0;
    int timeouts = 0;

    // Peripheral / bus monitor state
    int         rise_cnt, busy_cyc, low_run, txr_cyc, hs_cnt, und_cnt, overlap;
    logic       sclk_prev = 1'b0;
    logic       bit_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] poci_byte = 8'h00;
    logic [7:0] mem [256];
    logic [7:0] dec_addr;

    logic [7:0] tx_bytes [64];
    int         delays [64];
    int         exp_busy;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Peripheral model: samples pico on each sclk rise and presents the next poci bit.
    always @(negedge iclk) begin
        if (sclk && !sclk_prev) begin
            bit_q.push_back(pico);
            poci = poci_byte[rise_cnt % 8];
            rise_cnt++;
        end
        if (sclk)      low_run = 0;
        else if (busy) low_run++;
        if (busy)                 busy_cyc++;
        if (tx_ready)             txr_cyc++;
        if (tx_valid && tx_ready) hs_cnt++;
        if (rx_valid)             rx_q.push_back(rx_data);
        if (underrun)             und_cnt++;
        if (rx_valid && underrun) overlap++;
        sclk_prev = sclk;
    end

    task automatic clear_mon();
        rise_cnt = 0; busy_cyc = 0; low_run = 0; txr_cyc = 0;
        hs_cnt = 0; und_cnt = 0; overlap = 0;
        bit_q.delete();
        rx_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 'x;
        dec_addr = 'x;
    endtask

    // sel: 0 = cmd_ready, 1 = tx_ready, 2 = not busy
    task automatic wait_for(input int sel, input int budget);
        int n = 0;
        while (!((sel == 0 && cmd_ready) || (sel == 1 && tx_ready) || (sel == 2 && !busy))
               && n < budget) begin
            @(posedge iclk); #1;
            n++;
        end
        if (!((sel == 0 && cmd_ready) || (sel == 1 && tx_ready) || (sel == 2 && !busy)))
            timeouts++;
    endtask

    task automatic start_cmd(input logic [7:0] addr, input int len);
        @(posedge iclk); #1;
        cmd_addr  = addr;
        cmd_len   = len[5:0];
        cmd_valid = 1'b1;
        wait_for(0, 200);
        @(posedge iclk); #1;
        cmd_valid = 1'b0;
    endtask

    // Runs one frame supplying n_supply of len bytes, then decodes the captured pico stream.
    task automatic run_frame(input logic [7:0] addr, input int len, input int n_supply);
        logic [7:0] b;
        logic [7:0] idx;
        clear_mon();
        exp_busy = BYTE_CYC * (n_supply + 1) + IDLE_GAP;
        for (int i = 0; i < n_supply; i++) exp_busy += delays[i] + 1;
        if (n_supply < len) exp_busy += STALL;
        start_cmd(addr, len);
        for (int i = 0; i < n_supply; i++) begin
            if (delays[i] > 0) begin
                tx_valid = 1'b0;
                wait_for(1, 400);
                repeat (delays[i]) begin @(posedge iclk); #1; end
            end
            tx_valid = 1'b1;
            tx_data  = tx_bytes[i];
            wait_for(1, 400);
            @(posedge iclk); #1;
        end
        tx_valid = 1'b0;
        wait_for(2, 5000);
        @(negedge iclk); #1;
        for (int j = 0; j < bit_q.size() / 8; j++) begin
            for (int k = 0; k < 8; k++) b[k] = bit_q[8 * j + k];
            if (j == 0) dec_addr = b;
            else begin
                idx = dec_addr + 8'(j - 1);
                mem[idx] = b;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        n_checks++; if (sclk !== 1'b0)      begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        n_checks++; if (pico !== 1'b0)      begin n_fail++; $display("FAIL reset_pico: got %b expected 0", pico); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (underrun !== 1'b0)  begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        rstn = 1'b1;
        @(posedge iclk); #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        n_checks++; if (tx_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
    endtask

    task automatic test_single_byte();
        logic [15:0] got16;
        poci_byte   = 8'($urandom);
        tx_bytes[0] = 8'hA5;
        delays[0]   = 0;
        run_frame(8'h01, 1, 1);
        got16 = 'x;
        for (int i = 0; i < 16 && i < bit_q.size(); i++) got16[i] = bit_q[i];
        n_checks++; if (timeouts !== 0)   begin n_fail++; $display("FAIL single_timeout: got %0d expected 0", timeouts); end
        n_checks++; if (rise_cnt !== 16)  begin n_fail++; $display("FAIL single_rises: got %0d expected 16", rise_cnt); end
        n_checks++; if (got16 !== 16'hA501) begin n_fail++; $display("FAIL single_pico_bits: got %h expected a501", got16); end
        n_checks++; if (low_run !== IDLE_GAP) begin n_fail++; $display("FAIL single_gap_low: got %0d expected %0d", low_run, IDLE_GAP); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL single_cmd_ready: got %b expected 1", cmd_ready); end
        n_checks++; if (mem[1] !== 8'hA5) begin n_fail++; $display("FAIL single_reg1: got %h expected a5", mem[1]); end
        n_checks++; if (busy_cyc !== exp_busy) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected %0d", busy_cyc, exp_busy); end
        n_checks++; if (rx_q.size() !== (READBACK ? 1 : 0)) begin n_fail++; $display("FAIL single_rx_count: got %0d expected %0d", rx_q.size(), READBACK ? 1 : 0); end
        foreach (rx_q[i]) begin
            n_checks++; if (rx_q[i] !== poci_byte) begin n_fail++; $display("FAIL single_rx_data: got %h expected %h", rx_q[i], poci_byte); end
        end
    endtask

    task automatic test_back_to_back();
        poci_byte   = 8'h3C;
        tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
        for (int i = 0; i < 3; i++) delays[i] = 0;
        run_frame(8'd60, 3, 3);
        n_checks++; if (timeouts !== 0)  begin n_fail++; $display("FAIL b2b_timeout: got %0d expected 0", timeouts); end
        n_checks++; if (hs_cnt !== 3)    begin n_fail++; $display("FAIL b2b_handshakes: got %0d expected 3", hs_cnt); end
        n_checks++; if (txr_cyc !== 3)   begin n_fail++; $display("FAIL b2b_load_cycles: got %0d expected 3", txr_cyc); end
        n_checks++; if (rise_cnt !== 32) begin n_fail++; $display("FAIL b2b_rises: got %0d expected 32", rise_cnt); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mem[60 + i] !== tx_bytes[i]) begin n_fail++; $display("FAIL b2b_reg%0d: got %h expected %h", 60 + i, mem[60 + i], tx_bytes[i]); end
        end
        n_checks++; if (busy_cyc !== exp_busy) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", busy_cyc, exp_busy); end
        n_checks++; if (rx_q.size() !== (READBACK ? 3 : 0)) begin n_fail++; $display("FAIL b2b_rx_count: got %0d expected %0d", rx_q.size(), READBACK ? 3 : 0); end
        foreach (rx_q[i]) begin
            n_checks++; if (rx_q[i] !== 8'h3C) begin n_fail++; $display("FAIL b2b_rx_data: got %h expected 3c", rx_q[i]); end
        end
    endtask

    task automatic test_address_only();
        poci_byte = 8'($urandom);
        run_frame(8'h02, 0, 0);
        n_checks++; if (timeouts !== 0)    begin n_fail++; $display("FAIL addr_only_timeout: got %0d expected 0", timeouts); end
        n_checks++; if (rise_cnt !== 8)    begin n_fail++; $display("FAIL addr_only_rises: got %0d expected 8", rise_cnt); end
        n_checks++; if (dec_addr !== 8'h02) begin n_fail++; $display("FAIL addr_only_addr: got %h expected 02", dec_addr); end
        n_checks++; if (txr_cyc !== 0)     begin n_fail++; $display("FAIL addr_only_tx_ready: got %0d expected 0", txr_cyc); end
        n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL addr_only_rx: got %0d expected 0", rx_q.size()); end
        n_checks++; if (busy_cyc !== exp_busy) begin n_fail++; $display("FAIL addr_only_busy_cycles: got %0d expected %0d", busy_cyc, exp_busy); end
    endtask

    task automatic test_underrun();
        logic [7:0] addr;
        addr        = 8'($urandom);
        poci_byte   = 8'($urandom);
        tx_bytes[0] = 8'($urandom);
        delays[0]   = 0;
        run_frame(addr, 2, 1);
        n_checks++; if (timeouts !== 0)   begin n_fail++; $display("FAIL underrun_timeout: got %0d expected 0", timeouts); end
        n_checks++; if (und_cnt !== 1)    begin n_fail++; $display("FAIL underrun_pulses: got %0d expected 1", und_cnt); end
        n_checks++; if (rise_cnt !== 16)  begin n_fail++; $display("FAIL underrun_rises: got %0d expected 16", rise_cnt); end
        n_checks++; if (low_run !== STALL + IDLE_GAP) begin n_fail++; $display("FAIL underrun_low_run: got %0d expected %0d", low_run, STALL + IDLE_GAP); end
        n_checks++; if (busy_cyc !== exp_busy) begin n_fail++; $display("FAIL underrun_busy_cycles: got %0d expected %0d", busy_cyc, exp_busy); end
        n_checks++; if (mem[addr] !== tx_bytes[0]) begin n_fail++; $display("FAIL underrun_reg: got %h expected %h", mem[addr], tx_bytes[0]); end
        n_checks++; if (rx_q.size() !== (READBACK ? 1 : 0)) begin n_fail++; $display("FAIL underrun_rx_count: got %0d expected %0d", rx_q.size(), READBACK ? 1 : 0); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL underrun_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] addr;
        int         n = 0;
        clear_mon();
        addr = 8'($urandom) | 8'h10;
        start_cmd(addr, 1);
        while (rise_cnt < 5 && n < 200) begin @(posedge iclk); #1; n++; end
        n_checks++; if (sclk !== 1'b1 || pico !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got sclk=%b pico=%b expected 1 1", sclk, pico); end
        #2 rstn = 1'b0;
        #1;
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL midreset_sclk: got %b expected 0", sclk); end
        n_checks++; if (pico !== 1'b0) begin n_fail++; $display("FAIL midreset_pico: got %b expected 0", pico); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        #3 rstn = 1'b1;
        poci_byte   = 8'($urandom);
        tx_bytes[0] = 8'($urandom);
        delays[0]   = 1;
        run_frame(8'h7F, 1, 1);
        n_checks++; if (timeouts !== 0)  begin n_fail++; $display("FAIL midreset_timeout: got %0d expected 0", timeouts); end
        n_checks++; if (rise_cnt !== 16) begin n_fail++; $display("FAIL midreset_rises: got %0d expected 16", rise_cnt); end
        n_checks++; if (mem[8'h7F] !== tx_bytes[0]) begin n_fail++; $display("FAIL midreset_reg: got %h expected %h", mem[8'h7F], tx_bytes[0]); end
    endtask

    task automatic test_random();
        logic [7:0] addr;
        logic [7:0] idx;
        int         len;
        for (int f = 0; f < 6; f++) begin
            addr      = 8'($urandom);
            len       = $urandom_range(0, 6);
            poci_byte = 8'($urandom);
            for (int i = 0; i < len; i++) begin
                tx_bytes[i] = 8'($urandom);
                delays[i]   = $urandom_range(0, 3);
            end
            run_frame(addr, len, len);
            n_checks++; if (timeouts !== 0) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d expected 0", f, timeouts); end
            n_checks++; if (rise_cnt !== 8 * (len + 1)) begin n_fail++; $display("FAIL rand%0d_rises: got %0d expected %0d", f, rise_cnt, 8 * (len + 1)); end
            n_checks++; if (dec_addr !== addr) begin n_fail++; $display("FAIL rand%0d_addr: got %h expected %h", f, dec_addr, addr); end
            for (int i = 0; i < len; i++) begin
                idx = addr + 8'(i);
                n_checks++; if (mem[idx] !== tx_bytes[i]) begin n_fail++; $display("FAIL rand%0d_reg%0d: got %h expected %h", f, idx, mem[idx], tx_bytes[i]); end
            end
            n_checks++; if (busy_cyc !== exp_busy) begin n_fail++; $display("FAIL rand%0d_busy_cycles: got %0d expected %0d", f, busy_cyc, exp_busy); end
            n_checks++; if (hs_cnt !== len) begin n_fail++; $display("FAIL rand%0d_handshakes: got %0d expected %0d", f, hs_cnt, len); end
            n_checks++; if (und_cnt !== 0)  begin n_fail++; $display("FAIL rand%0d_underrun: got %0d expected 0", f, und_cnt); end
            n_checks++; if (overlap !== 0)  begin n_fail++; $display("FAIL rand%0d_overlap: got %0d expected 0", f, overlap); end
            n_checks++; if (rx_q.size() !== (READBACK ? len : 0)) begin n_fail++; $display("FAIL rand%0d_rx_count: got %0d expected %0d", f, rx_q.size(), READBACK ? len : 0); end
            foreach (rx_q[i]) begin
                n_checks++; if (rx_q[i] !== poci_byte) begin n_fail++; $display("FAIL rand%0d_rx_data: got %h expected %h", f, rx_q[i], poci_byte); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_address_only();
        test_underrun();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
